// File: rtl/trace_stream_emitter_pkg.sv
// Shared definitions for the retirement trace emitter: snapshot layout,
// flag bit positions, header tag, serialiser states and word selection helpers.
package trace_stream_emitter_pkg;

    localparam int unsigned FLAG_RW = 0;
    localparam int unsigned FLAG_MR = 1;
    localparam int unsigned FLAG_MW = 2;
    localparam int unsigned FLAG_H  = 3;

    localparam logic [3:0] HDR_TAG = 4'hA;
    localparam int unsigned SNAP_W = 56;

    typedef struct packed {
        logic [3:0]  flags;     // {H, MW, MR, RW}
        logic [3:0]  wb_reg;
        logic [15:0] wb_data;
        logic [15:0] mem_addr;
        logic [15:0] mem_data;  // load data if MR, else store data
    } snap_t;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StRdata,
        StAddr,
        StMdata,
        StCyc,
        StInst,
        StDone
    } ser_state_e;

    function automatic logic [15:0] hdr_word(input snap_t s);
        return {HDR_TAG, s.flags, 4'h0, s.wb_reg};
    endfunction

    // Word that follows `st` within a record; StIdle marks end of a plain record.
    function automatic ser_state_e next_state(input ser_state_e st, input logic [3:0] flags);
        logic has_mem;
        has_mem = flags[FLAG_MR] | flags[FLAG_MW];
        case (st)
            StHdr: begin
                if (flags[FLAG_RW])     return StRdata;
                else if (has_mem)       return StAddr;
                else if (flags[FLAG_H]) return StCyc;
                else                    return StIdle;
            end
            StRdata: begin
                if (has_mem)            return StAddr;
                else if (flags[FLAG_H]) return StCyc;
                else                    return StIdle;
            end
            StAddr:  return StMdata;
            StMdata: return flags[FLAG_H] ? StCyc : StIdle;
            StCyc:   return StInst;
            StInst:  return StDone;
            default: return StIdle;
        endcase
    endfunction

    function automatic logic [15:0] word_for(input ser_state_e st, input snap_t s,
                                             input logic [15:0] cyc, input logic [15:0] inst);
        case (st)
            StRdata: return s.wb_data;
            StAddr:  return s.mem_addr;
            StMdata: return s.mem_data;
            StCyc:   return cyc;
            StInst:  return inst;
            default: return hdr_word(s);
        endcase
    endfunction

endpackage

// File: rtl/trace_stream_emitter_snap_fifo.sv
// Synchronous snapshot FIFO. Exposes the head and the entry behind it so the
// serialiser can start the next record in the same cycle it retires one.
module trace_snap_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 56
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] next_head,
    output logic             full,
    output logic             empty,
    output logic             more_than_one
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr_q, wptr_q;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full          = (count_q == (AW+1)'(DEPTH));
    assign empty         = (count_q == '0);
    assign more_than_one = (count_q > (AW+1)'(1));
    assign pop_ok        = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign push_ok       = push && (!full || pop_ok);
    assign head          = mem[rptr_q];
    assign next_head     = mem[rptr_q + AW'(1)];

    // Occupancy next-state.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop_ok)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q] <= push_data;
    end

endmodule

// File: rtl/trace_stream_emitter.sv
// Retirement trace emitter: captures commit events into a snapshot FIFO and
// serialises them as 16-bit words on a valid/ready stream, ending with a halt summary.
module trace_stream_emitter
    import trace_stream_emitter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_regwrite,
    input  logic [3:0]  wb_reg,
    input  logic [15:0] wb_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic [15:0] mem_wdata,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        overflow,
    output logic        done
);

    logic             halted_q;
    logic [CNT_W-1:0] cyc_q, inst_q;
    logic             pend_valid_q, pend_valid_d;
    snap_t            pend_q, pend_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      out_data_q, out_data_d;
    ser_state_e       state_q, state_d, nxt;

    snap_t            snap, head, next_head, push_snap;
    logic [SNAP_W-1:0] head_raw, next_head_raw;
    logic             capture, can_push, push, pop;
    logic             fifo_full, fifo_empty, fifo_multi;
    logic [15:0]      cyc_word, inst_word;

    assign capture = !halted_q && (halt | mem_write | mem_read | wb_regwrite);

    assign snap.flags    = {halt, mem_write, mem_read, wb_regwrite};
    assign snap.wb_reg   = wb_reg;
    assign snap.wb_data  = wb_data;
    assign snap.mem_addr = mem_addr;
    assign snap.mem_data = mem_read ? mem_rdata : mem_wdata;

    assign head      = head_raw;
    assign next_head = next_head_raw;
    assign cyc_word  = 16'(cyc_q);
    assign inst_word = 16'(inst_q);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overflow  = overflow_q;
    assign done      = done_q;

    trace_snap_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SNAP_W)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push          (push),
        .push_data     (push_snap),
        .pop           (pop),
        .head          (head_raw),
        .next_head     (next_head_raw),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .more_than_one (fifo_multi)
    );

    // Capture path: push snapshot, park a halt that meets a full FIFO, flag drops.
    always_comb begin
        push         = 1'b0;
        push_snap    = snap;
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        overflow_d   = overflow_q;
        can_push     = !fifo_full || pop;
        if (pend_valid_q) begin
            // Inputs are already ignored here; only the parked halt competes for the slot.
            push_snap = pend_q;
            if (can_push) begin
                push         = 1'b1;
                pend_valid_d = 1'b0;
            end
        end else if (capture) begin
            if (can_push) begin
                push = 1'b1;
            end else if (halt) begin
                pend_valid_d = 1'b1;
                pend_d       = snap;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // Serialiser: walks the head record word by word, pops on its last word.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = done_q;
        pop         = 1'b0;
        nxt         = StIdle;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d     = StHdr;
                    out_valid_d = 1'b1;
                    out_data_d  = hdr_word(head);
                end
            end
            StDone: begin
                out_valid_d = 1'b0;
            end
            default: begin
                if (out_valid_q && out_ready) begin
                    nxt = next_state(state_q, head.flags);
                    if (nxt == StIdle) begin
                        pop = 1'b1;
                        if (fifo_multi) begin
                            state_d    = StHdr;
                            out_data_d = hdr_word(next_head);
                        end else begin
                            state_d     = StIdle;
                            out_valid_d = 1'b0;
                        end
                    end else if (nxt == StDone) begin
                        pop         = 1'b1;
                        done_d      = 1'b1;
                        out_valid_d = 1'b0;
                        state_d     = StDone;
                    end else begin
                        state_d    = nxt;
                        out_data_d = word_for(nxt, head, cyc_word, inst_word);
                    end
                end
            end
        endcase
    end

    // Counters run until halt is captured (halt cycle included), then freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
            cyc_q    <= '0;
            inst_q   <= '0;
        end else if (!halted_q) begin
            if (cyc_q != '1) cyc_q <= cyc_q + CNT_W'(1);
            if ((halt | wb_regwrite | mem_write) && (inst_q != '1)) inst_q <= inst_q + CNT_W'(1);
            if (halt) halted_q <= 1'b1;
        end
    end

    // Capture, serialiser and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            state_q      <= StIdle;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            state_q      <= state_d;
        end
    end

endmodule

// File: tb/tb_trace_stream_emitter.sv
// Self-checking bench for trace_stream_emitter: directed scenarios plus random
// traffic scored against a record-level model of the trace stream.
module tb_trace_stream_emitter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_regwrite = 1'b0;
    logic [3:0]  wb_reg = '0;
    logic [15:0] wb_data = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] mem_wdata = '0;
    logic        halt = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_data;
    logic        overflow;
    logic        done;

    always #5 clk = ~clk;

    trace_stream_emitter #(
        .DEPTH (DEPTH),
        .CNT_W (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_regwrite (wb_regwrite),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_wdata   (mem_wdata),
        .halt        (halt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .overflow    (overflow),
        .done        (done)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: records waiting to be sent, as flat word list + per-record length.
    logic [15:0] exp_words[$];
    int          rec_len[$];
    bit          rec_halt[$];
    int          head_idx;
    bit          pend;
    logic [15:0] pend_words[$];
    bit          m_halted, m_ovf, m_done;
    int unsigned m_cyc, m_inst;
    bit          prev_stall;
    logic [15:0] prev_data;
    logic [15:0] acc_log[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_words.delete();
        rec_len.delete();
        rec_halt.delete();
        pend_words.delete();
        acc_log.delete();
        head_idx   = 0;
        pend       = 0;
        m_halted   = 0;
        m_ovf      = 0;
        m_done     = 0;
        m_cyc      = 0;
        m_inst     = 0;
        prev_stall = 0;
    endtask

    // One clock cycle: check outputs, drive inputs, advance model at the edge.
    task automatic tick(input logic h, input logic mw, input logic mr, input logic rw,
                        input logic [3:0] rg, input logic [15:0] wd, input logic [15:0] ad,
                        input logic [15:0] rdt, input logic [15:0] wdt, input logic rdy);
        logic        s_valid;
        logic [15:0] s_data;
        bit          hs;
        logic [15:0] w[$];
        s_valid = out_valid;
        s_data  = out_data;
        if (prev_stall) begin
            check_eq("stall_valid", s_valid, 1);
            check_eq("stall_data", s_data, prev_data);
        end
        check_eq("overflow", overflow, m_ovf);
        check_eq("done", done, m_done);
        if (m_done) check_eq("valid_after_done", s_valid, 0);

        halt = h; mem_write = mw; mem_read = mr; wb_regwrite = rw; wb_reg = rg;
        wb_data = wd; mem_addr = ad; mem_rdata = rdt; mem_wdata = wdt; out_ready = rdy;
        hs = s_valid && rdy;
        @(posedge clk);

        if (hs) begin
            acc_log.push_back(s_data);
            if (rec_len.size() == 0) begin
                check_eq("spurious_valid", s_valid, 0);
            end else begin
                check_eq("word", s_data, exp_words.pop_front());
                head_idx++;
                if (head_idx == rec_len[0]) begin
                    if (rec_halt[0]) m_done = 1;
                    void'(rec_len.pop_front());
                    void'(rec_halt.pop_front());
                    head_idx = 0;
                end
            end
        end
        if (!m_halted) begin
            if (m_cyc < 32'hFFFF) m_cyc++;
            if ((h | rw | mw) && m_inst < 32'hFFFF) m_inst++;
        end
        if (pend) begin
            if (rec_len.size() < DEPTH) begin
                foreach (pend_words[i]) exp_words.push_back(pend_words[i]);
                rec_len.push_back(pend_words.size());
                rec_halt.push_back(1'b1);
                pend = 0;
            end
        end else if (!m_halted && (h | mw | mr | rw)) begin
            w.push_back({4'hA, h, mw, mr, rw, 4'h0, rg});
            if (rw) w.push_back(wd);
            if (mr | mw) begin
                w.push_back(ad);
                w.push_back(mr ? rdt : wdt);
            end
            if (h) begin
                w.push_back(m_cyc[15:0]);
                w.push_back(m_inst[15:0]);
            end
            if (rec_len.size() < DEPTH) begin
                foreach (w[i]) exp_words.push_back(w[i]);
                rec_len.push_back(w.size());
                rec_halt.push_back(h);
            end else if (h) begin
                pend       = 1;
                pend_words = w;
            end else begin
                m_ovf = 1;
            end
        end
        if (!m_halted && h) m_halted = 1;
        prev_stall = s_valid && !rdy;
        prev_data  = s_data;
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, rdy);
    endtask

    task automatic rw_ev(input logic [3:0] rg, input logic [15:0] d, input logic rdy);
        tick(1'b0, 1'b0, 1'b0, 1'b1, rg, d, 16'h0, 16'h0, 16'h0, rdy);
    endtask

    // Asynchronous reset pulse in mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_data", out_data, 16'h0);
        model_clear();
        halt = 0; mem_write = 0; mem_read = 0; wb_regwrite = 0; out_ready = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (rec_len.size() != 0 || pend); i++) idle(1'b1);
        check_eq("drain_empty", rec_len.size() + int'(pend), 0);
    endtask

    initial begin
        logic [15:0] exp2 [6];
        model_clear();
        @(negedge clk);
        do_reset();

        // Single register write.
        rw_ev(4'd3, 16'h1234, 1'b1);
        for (int i = 0; i < 6; i++) idle(1'b1);
        check_eq("t1_len", acc_log.size(), 2);
        check_eq("t1_hdr", acc_log[0], 16'hA103);
        check_eq("t1_data", acc_log[1], 16'h1234);
        check_eq("t1_ovf", overflow, 0);

        // Store then load of the same address.
        acc_log.delete();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0040, 16'h0, 16'hBEEF, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0, 16'h0040, 16'h00FF, 16'h0, 1'b1);
        for (int i = 0; i < 10; i++) idle(1'b1);
        exp2 = '{16'hA400, 16'h0040, 16'hBEEF, 16'hA200, 16'h0040, 16'h00FF};
        check_eq("t2_len", acc_log.size(), 6);
        for (int i = 0; i < 6 && i < acc_log.size(); i++) check_eq("t2_word", acc_log[i], exp2[i]);

        // Six writes with consumer stalled: four survive, overflow sticks.
        do_reset();
        for (int i = 0; i < 6; i++) rw_ev(4'(i), 16'(16'h100 + i), 1'b0);
        check_eq("t3_ovf", overflow, 1);
        drain();
        for (int i = 0; i < 4; i++) idle(1'b1);
        check_eq("t3_len", acc_log.size(), 8);
        check_eq("t3_ovf_sticky", overflow, 1);

        // Load record under a toggling ready.
        do_reset();
        tick(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0, 16'h1230, 16'h5A5A, 16'h0, 1'b0);
        for (int i = 0; i < 12; i++) idle(1'(i));
        check_eq("t4_len", acc_log.size(), 3);
        if (acc_log.size() == 3) begin
            check_eq("t4_hdr", acc_log[0], 16'hA200);
            check_eq("t4_addr", acc_log[1], 16'h1230);
            check_eq("t4_data", acc_log[2], 16'h5A5A);
        end

        // Halt on cycle 10 after three writes; later events ignored.
        do_reset();
        rw_ev(4'd1, 16'h0011, 1'b1);
        rw_ev(4'd2, 16'h0022, 1'b1);
        rw_ev(4'd3, 16'h0033, 1'b1);
        for (int i = 0; i < 6; i++) idle(1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
        for (int i = 0; i < 8; i++) idle(1'b1);
        for (int i = 0; i < 4; i++) rw_ev(4'd5, 16'hDEAD, 1'b1);
        check_eq("t5_len", acc_log.size(), 9);
        if (acc_log.size() >= 9) begin
            check_eq("t5_hdr", acc_log[6], 16'hA800);
            check_eq("t5_cyc", acc_log[7], 16'h000A);
            check_eq("t5_inst", acc_log[8], 16'h0004);
        end
        check_eq("t5_done", done, 1);

        // Halt arrives with FIFO full and consumer stalled.
        do_reset();
        for (int i = 0; i < 4; i++) rw_ev(4'(i + 8), 16'(16'h200 + i), 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        idle(1'b0);
        drain();
        idle(1'b1);
        check_eq("t6_len", acc_log.size(), 11);
        if (acc_log.size() >= 11) check_eq("t6_hdr", acc_log[8], 16'hA800);
        check_eq("t6_done", done, 1);
        check_eq("t6_ovf", overflow, 0);

        // Reset in the middle of a record.
        do_reset();
        rw_ev(4'd7, 16'h7777, 1'b0);
        idle(1'b0);
        check_eq("t6_pre_rst_valid", out_valid, 1);
        do_reset();
        idle(1'b1);
        check_eq("t6_post_rst_valid", out_valid, 0);

        // Random traffic against the model.
        for (int r = 0; r < 4; r++) begin
            int ev_pct, rdy_pct;
            do_reset();
            ev_pct  = 20 + 20 * r;
            rdy_pct = 90 - 20 * r;
            for (int c = 0; c < 400; c++) begin
                logic e, h, mw, mr, rw;
                e  = 1'($urandom_range(99) < ev_pct);
                h  = e & 1'($urandom_range(149) == 0);
                mw = e & 1'($urandom_range(1));
                mr = e & 1'($urandom_range(1));
                rw = e & (1'($urandom_range(1)) | !(h | mw | mr));
                tick(h, mw, mr, rw, 4'($urandom), 16'($urandom), 16'($urandom),
                     16'($urandom), 16'($urandom), 1'($urandom_range(99) < rdy_pct));
            end
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
